// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        OP   = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic MODE_MUL = 1'b1;
    localparam logic MODE_DIV = 1'b0;

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// Issue-side handshake and datapath-control bundle of the multiply/divide sequencer.
interface muldiv_seq_ctrl_if #(
    parameter int WIDTH = 64
);
    localparam int CW = $clog2(WIDTH + 1);

    logic          start;
    logic          m_d;
    logic          signed_op;
    logic          a_sign;
    logic          b_sign;
    logic          divisor_zero;
    logic          abort;
    logic [1:0]    data_in;

    logic          ready;
    logic          busy;
    logic          done;
    logic          err_div0;
    logic          alu_sel;
    logic          initial_wr;
    logic          wr;
    logic          sh_right;
    logic          sh_left;
    logic          neg_fix;
    logic          rem_fix;
    logic [CW-1:0] count;

    modport master (
        output start, m_d, signed_op, a_sign, b_sign, divisor_zero, abort, data_in,
        input  ready, busy, done, err_div0, alu_sel, initial_wr, wr,
               sh_right, sh_left, neg_fix, rem_fix, count
    );

    modport slave (
        input  start, m_d, signed_op, a_sign, b_sign, divisor_zero, abort, data_in,
        output ready, busy, done, err_div0, alu_sel, initial_wr, wr,
               sh_right, sh_left, neg_fix, rem_fix, count
    );

endinterface

// File: rtl/muldiv_seq_ctrl.sv
// Control FSM for the shared shift-add multiplier / shift-subtract divider datapath.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter bit SIGNED_EN = 1'b1
) (
    input logic             clk,
    input logic             reset,
    muldiv_seq_ctrl_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state, state_nx;
    logic [CW-1:0] count;
    logic          mode_q, neg_q, remneg_q, z_q, err_q;
    logic          sgn_req, fix_needed;

    assign sgn_req    = SIGNED_EN & bus.signed_op;
    assign fix_needed = SIGNED_EN & (neg_q | remneg_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            mode_q   <= MODE_DIV;
            neg_q    <= 1'b0;
            remneg_q <= 1'b0;
            z_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.start) begin
                    mode_q   <= bus.m_d;
                    neg_q    <= sgn_req & (bus.a_sign ^ bus.b_sign);
                    remneg_q <= sgn_req & ~bus.m_d & bus.a_sign;
                    z_q      <= ~bus.m_d & bus.divisor_zero;
                    err_q    <= 1'b0;
                end
                // An abort in LOAD leaves the error flag untouched even for a zero divisor.
                LOAD: begin
                    count <= '0;
                    if (z_q && !bus.abort) err_q <= 1'b1;
                end
                OP:      count <= count + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = LOAD;
            LOAD: begin
                if (bus.abort)  state_nx = IDLE;
                else if (z_q)   state_nx = DONE;
                else            state_nx = OP;
            end
            OP: begin
                if (bus.abort)          state_nx = IDLE;
                else if (count == LAST) state_nx = fix_needed ? FIX : DONE;
            end
            FIX:     state_nx = bus.abort ? IDLE : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.ready      = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.err_div0   = err_q;
    assign bus.alu_sel    = mode_q;
    assign bus.initial_wr = (state == LOAD);
    assign bus.sh_right   = (state == OP) & mode_q;
    assign bus.sh_left    = (state == OP) & ~mode_q;
    assign bus.wr         = (state == OP) &
                            ((mode_q & bus.data_in[0]) | (~mode_q & ~bus.data_in[1]));
    assign bus.neg_fix    = (state == FIX) & neg_q;
    assign bus.rem_fix    = (state == FIX) & remneg_q;
    assign bus.count      = count;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl at WIDTH=8, with a SIGNED_EN=0 twin on the same stimulus.
module tb_muldiv_seq_ctrl;
    import muldiv_pkg::*;

    logic clk, reset;
    logic start, m_d, signed_op, a_sign, b_sign, divisor_zero, abort;
    logic [1:0] data_in;
    int tests = 0;
    int fails = 0;
    logic nf0_seen = 1'b0;

    muldiv_seq_ctrl_if #(.WIDTH(8)) bus1 ();
    muldiv_seq_ctrl_if #(.WIDTH(8)) bus0 ();

    assign bus1.start = start;         assign bus0.start = start;
    assign bus1.m_d = m_d;             assign bus0.m_d = m_d;
    assign bus1.signed_op = signed_op; assign bus0.signed_op = signed_op;
    assign bus1.a_sign = a_sign;       assign bus0.a_sign = a_sign;
    assign bus1.b_sign = b_sign;       assign bus0.b_sign = b_sign;
    assign bus1.divisor_zero = divisor_zero; assign bus0.divisor_zero = divisor_zero;
    assign bus1.abort = abort;         assign bus0.abort = abort;
    assign bus1.data_in = data_in;     assign bus0.data_in = data_in;

    muldiv_seq_ctrl #(.WIDTH(8), .SIGNED_EN(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus1));
    muldiv_seq_ctrl #(.WIDTH(8), .SIGNED_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus0.neg_fix || bus0.rem_fix) nf0_seen <= 1'b1;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // {ready,busy,done,err_div0,initial_wr,wr,sh_right,sh_left,neg_fix,rem_fix,alu_sel}
    function automatic logic [10:0] pack1();
        return {bus1.ready, bus1.busy, bus1.done, bus1.err_div0, bus1.initial_wr, bus1.wr,
                bus1.sh_right, bus1.sh_left, bus1.neg_fix, bus1.rem_fix, bus1.alu_sel};
    endfunction

    function automatic logic [10:0] pack0();
        return {bus0.ready, bus0.busy, bus0.done, bus0.err_div0, bus0.initial_wr, bus0.wr,
                bus0.sh_right, bus0.sh_left, bus0.neg_fix, bus0.rem_fix, bus0.alu_sel};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        start;
        logic        m_d;
        logic [1:0]  din;
        logic [10:0] ctl;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[12];
    int   done_at;
    logic done_seen;

    initial begin
        // Unsigned multiply, multiplier 8'hA5 LSB-first; m_d and data_in[1] wiggle mid-op,
        // start is pulsed in OP and DONE.
        tbl[0]  = '{1'b1, 1'b1, 2'b00, 11'b10000000000, 4'd0};
        tbl[1]  = '{1'b0, 1'b0, 2'b00, 11'b01001000001, 4'd0};
        tbl[2]  = '{1'b0, 1'b0, 2'b01, 11'b01000110001, 4'd0};
        tbl[3]  = '{1'b0, 1'b0, 2'b10, 11'b01000010001, 4'd1};
        tbl[4]  = '{1'b0, 1'b0, 2'b01, 11'b01000110001, 4'd2};
        tbl[5]  = '{1'b1, 1'b0, 2'b10, 11'b01000010001, 4'd3};
        tbl[6]  = '{1'b0, 1'b0, 2'b10, 11'b01000010001, 4'd4};
        tbl[7]  = '{1'b0, 1'b0, 2'b11, 11'b01000110001, 4'd5};
        tbl[8]  = '{1'b0, 1'b0, 2'b00, 11'b01000010001, 4'd6};
        tbl[9]  = '{1'b0, 1'b0, 2'b01, 11'b01000110001, 4'd7};
        tbl[10] = '{1'b1, 1'b1, 2'b00, 11'b01100000001, 4'd8};
        tbl[11] = '{1'b0, 1'b0, 2'b00, 11'b10000000001, 4'd8};

        reset = 1'b1; start = 1'b0; m_d = 1'b0; signed_op = 1'b0; a_sign = 1'b0;
        b_sign = 1'b0; divisor_zero = 1'b0; abort = 1'b0; data_in = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_ctl", 16'(pack1()), 16'b10000000000);
        chk("reset_cnt", 16'(bus1.count), 16'd0);
        chk("reset_ctl_se0", 16'(pack0()), 16'b10000000000);

        for (int i = 0; i < 12; i++) begin
            start = tbl[i].start; m_d = tbl[i].m_d; data_in = tbl[i].din;
            #1;
            chk($sformatf("mul_ctl[%0d]", i), 16'(pack1()), 16'(tbl[i].ctl));
            chk($sformatf("mul_cnt[%0d]", i), 16'(bus1.count), 16'(tbl[i].cnt));
            tick();
        end

        // Signed divide, a negative / b positive: fix cycle on the signed build only.
        start = 1'b1; m_d = 1'b0; signed_op = 1'b1; a_sign = 1'b1; b_sign = 1'b0; data_in = 2'b00;
        tick();
        start = 1'b0; signed_op = 1'b0; a_sign = 1'b0; m_d = 1'b1;
        #1 chk("sdiv_load_init", 16'({bus1.initial_wr, bus1.alu_sel}), 16'b10);
        tick();
        for (int k = 0; k < 8; k++) begin
            data_in = {k[0], 1'b0};
            #1 chk($sformatf("sdiv_op[%0d]", k),
                   16'({bus1.sh_left, bus1.wr, bus1.sh_right}), 16'({1'b1, ~k[0], 1'b0}));
            tick();
        end
        data_in = 2'b00;
        chk("sdiv_fix", 16'({bus1.done, bus1.neg_fix, bus1.rem_fix, bus1.busy}), 16'b0111);
        chk("sdiv_se0_done10", 16'({bus0.done, bus0.neg_fix, bus0.rem_fix, bus0.ready}), 16'b1000);
        tick();
        chk("sdiv_done11", 16'({bus1.done, bus1.neg_fix, bus1.rem_fix}), 16'b100);
        chk("sdiv_se0_ready11", 16'(bus0.ready), 16'd1);
        tick();
        chk("sdiv_ready12", 16'(bus1.ready), 16'd1);

        // Divide by zero short-circuit.
        start = 1'b1; m_d = 1'b0; divisor_zero = 1'b1;
        tick();
        start = 1'b0; divisor_zero = 1'b0;
        #1 chk("div0_load", 16'({bus1.initial_wr, bus1.err_div0}), 16'b10);
        tick();
        chk("div0_done", 16'({bus1.done, bus1.err_div0, bus1.sh_left, bus1.wr}), 16'b1100);
        tick();
        chk("div0_idle", 16'({bus1.ready, bus1.err_div0}), 16'b11);
        repeat (3) tick();
        chk("div0_sticky", 16'(bus1.err_div0), 16'd1);

        // Abort at OP count 3.
        start = 1'b1; m_d = 1'b1; data_in = 2'b01;
        #1 chk("abort_err_before", 16'(bus1.err_div0), 16'd1);
        tick();
        start = 1'b0;
        #1 chk("abort_err_cleared", 16'(bus1.err_div0), 16'd0);
        repeat (4) tick();
        chk("abort_cnt3", 16'(bus1.count), 16'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1 chk("abort_idle", 16'({bus1.ready, bus1.busy, bus1.done}), 16'b100);
        done_seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (bus1.done) done_seen = 1'b1;
            tick();
        end
        chk("abort_no_done", 16'(done_seen), 16'd0);

        start = 1'b1; m_d = 1'b1;
        tick();
        start = 1'b0;
        done_at = 99;
        for (int n = 1; n <= 20; n++) begin
            #1 if (bus1.done && done_at == 99) done_at = n;
            tick();
        end
        chk("rerun_done_latency", 16'(done_at), 16'd10);

        // Reset mid-operation overrides start and abort.
        start = 1'b1; m_d = 1'b0; signed_op = 1'b1; a_sign = 1'b1; b_sign = 1'b1; data_in = 2'b00;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("rst_cnt5", 16'(bus1.count), 16'd5);
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        #1;
        chk("rst_ctl", 16'(pack1()), 16'b10000000000);
        chk("rst_cnt", 16'(bus1.count), 16'd0);
        chk("rst_ctl_se0", 16'(pack0()), 16'b10000000000);
        tick();
        chk("se0_never_fix", 16'(nf0_seen), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
